// File: rtl/gsim_ctrl_if.sv
// Handshake bundle between the GSIM sequencing controller and the solver datapath.
// The controller takes the master modport; the datapath (or a bench model) takes the slave modport.
interface gsim_ctrl_if #(
  parameter int AW  = 4,
  parameter int ITW = 8
);
  logic           in_en;
  logic           b_wr_en;
  logic [AW-1:0]  b_wr_addr;
  logic           x_clr;
  logic           upd_start;
  logic [AW-1:0]  upd_idx;
  logic           upd_done;
  logic           upd_small;
  logic           x_rd_en;
  logic [AW-1:0]  x_rd_addr;
  logic           out_valid;
  logic           busy;
  logic [ITW-1:0] iter_count;

  modport master (
    input  in_en, upd_done, upd_small,
    output b_wr_en, b_wr_addr, x_clr, upd_start, upd_idx,
           x_rd_en, x_rd_addr, out_valid, busy, iter_count
  );

  modport slave (
    output in_en, upd_done, upd_small,
    input  b_wr_en, b_wr_addr, x_clr, upd_start, upd_idx,
           x_rd_en, x_rd_addr, out_valid, busy, iter_count
  );
endinterface

// File: rtl/gsim_ctrl.sv
// GSIM Gauss-Seidel sequencer: loads b, sweeps rows through the shared update unit
// until convergence or the sweep cap, then streams x out over N back-to-back cycles.
module gsim_ctrl #(
  parameter int N        = 16,
  parameter int MAX_ITER = 64,
  parameter int MIN_ITER = 8,
  parameter int ITW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  gsim_ctrl_if.master bus_io
);
  localparam int AW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_SWEEP_END, S_OUT, S_OUT_TAIL
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  load_cnt_q, load_cnt_d;
  logic [AW-1:0]  row_q, row_d;
  logic [AW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic           sweep_small_q, sweep_small_d;
  logic           upd_start_q, x_rd_en_q, out_valid_q, busy_q;
  logic           accept, last_sample;

  // Samples are only taken while idle or loading; anything later is dropped.
  assign accept      = bus_io.in_en && (state_q == S_IDLE || state_q == S_LOAD);
  assign last_sample = (load_cnt_q == AW'(N - 1));

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    row_d         = row_q;
    rd_cnt_d      = rd_cnt_q;
    iter_d        = iter_q;
    sweep_small_d = sweep_small_q;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (state_q == S_IDLE) iter_d = '0;
          if (last_sample) begin
            load_cnt_d = '0;
            state_d    = S_ISSUE;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_ISSUE: begin
        if (row_q == '0) sweep_small_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_io.upd_done) begin
          sweep_small_d = sweep_small_q & bus_io.upd_small;
          if (row_q == AW'(N - 1)) begin
            state_d = S_SWEEP_END;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_SWEEP_END: begin
        iter_d = iter_q + 1'b1;
        row_d  = '0;
        // Convergence only counts once the minimum number of sweeps is behind us.
        if (iter_d == ITW'(MAX_ITER) || (sweep_small_q && iter_d >= ITW'(MIN_ITER))) begin
          rd_cnt_d = '0;
          state_d  = S_OUT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_OUT: begin
        if (rd_cnt_q == AW'(N - 1)) begin
          rd_cnt_d = '0;
          state_d  = S_OUT_TAIL;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_OUT_TAIL: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      load_cnt_q    <= '0;
      row_q         <= '0;
      rd_cnt_q      <= '0;
      iter_q        <= '0;
      sweep_small_q <= 1'b0;
      upd_start_q   <= 1'b0;
      x_rd_en_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      row_q         <= row_d;
      rd_cnt_q      <= rd_cnt_d;
      iter_q        <= iter_d;
      sweep_small_q <= sweep_small_d;
      upd_start_q   <= (state_d == S_ISSUE);
      x_rd_en_q     <= (state_d == S_OUT);
      out_valid_q   <= x_rd_en_q;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign bus_io.b_wr_en    = accept;
  assign bus_io.b_wr_addr  = load_cnt_q;
  assign bus_io.x_clr      = accept && last_sample;
  assign bus_io.upd_start  = upd_start_q;
  assign bus_io.upd_idx    = row_q;
  assign bus_io.x_rd_en    = x_rd_en_q;
  assign bus_io.x_rd_addr  = rd_cnt_q;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.iter_count = iter_q;
endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed bench for gsim_ctrl: table-driven load vectors plus hand-written sweep,
// convergence, reset-abort and timing sequences against a small latency model of the datapath.
module tb_gsim_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gsim_ctrl_if #(.AW(4), .ITW(8)) ia ();
  gsim_ctrl_if #(.AW(4), .ITW(8)) ib ();

  gsim_ctrl #(.N(16), .MAX_ITER(64), .MIN_ITER(8), .ITW(8)) dut_a (
    .clk(clk), .reset(reset), .bus_io(ia)
  );
  gsim_ctrl #(.N(16), .MAX_ITER(4), .MIN_ITER(2), .ITW(8)) dut_b (
    .clk(clk), .reset(reset), .bus_io(ib)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Datapath model for dut_a: upd_done lat_a cycles after upd_start, with a selectable
  // upd_small policy and optional spurious done pulses in ISSUE and OUT.
  int lat_a = 1;
  int small_mode = 1;  // 0: never small, 1: always small, 2: one non-small row in sweep 8
  int pend_a = 0;
  int starts_a = 0;
  int dones_a = 0;
  bit inj_issue = 1'b0;
  bit inj_out = 1'b0;

  function automatic logic small_fn(input int mode, input int done_no);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return !((done_no / 16 + 1) == 8 && (done_no % 16) == 5);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pend_a       = 0;
      ia.upd_done  = 1'b0;
      ia.upd_small = 1'b0;
    end else begin
      ia.upd_done = 1'b0;
      if (pend_a > 0) begin
        pend_a--;
        if (pend_a == 0) begin
          ia.upd_done  = 1'b1;
          ia.upd_small = small_fn(small_mode, dones_a);
          dones_a++;
        end
      end
      if (ia.upd_start) begin
        check("a_upd_idx_seq", ia.upd_idx, 32'(starts_a % 16));
        starts_a++;
        pend_a = lat_a;
        if (inj_issue) begin
          ia.upd_done  = 1'b1;
          ia.upd_small = 1'b0;
        end
      end
      if (ia.x_rd_en && inj_out) begin
        ia.upd_done  = 1'b1;
        ia.upd_small = 1'b0;
      end
    end
  end

  // Datapath model for dut_b: fixed latency 3, never small; also checks start spacing.
  int pend_b = 0;
  int starts_b = 0;
  int last_start_b = 0;

  always @(negedge clk) begin
    if (reset) begin
      pend_b       = 0;
      ib.upd_done  = 1'b0;
      ib.upd_small = 1'b0;
    end else begin
      ib.upd_done = 1'b0;
      if (pend_b > 0) begin
        pend_b--;
        if (pend_b == 0) begin
          ib.upd_done  = 1'b1;
          ib.upd_small = 1'b0;
        end
      end
      if (ib.upd_start) begin
        check("b_upd_idx_seq", ib.upd_idx, 32'(starts_b % 16));
        if (starts_b > 0)
          check("b_start_spacing", 32'(cyc - last_start_b), (starts_b % 16 == 0) ? 32'd5 : 32'd4);
        last_start_b = cyc;
        starts_b++;
        pend_b = 3;
      end
    end
  end

  // Continuous 16-sample load into dut_a; entered and left just after a falling edge.
  task automatic load_a();
    for (int i = 0; i < 16; i++) begin
      ia.in_en = 1'b1;
      #1;
      check("a_load_wr_en", ia.b_wr_en, 1);
      check("a_load_wr_addr", ia.b_wr_addr, 32'(i));
      check("a_load_x_clr", ia.x_clr, 32'(i == 15));
      @(negedge clk);
    end
    ia.in_en = 1'b0;
    #1;
    check("a_first_upd_start", ia.upd_start, 1);
    check("a_first_upd_idx", ia.upd_idx, 0);
    check("a_x_clr_single", ia.x_clr, 0);
  endtask

  // Wait for dut_a output phase and check the 16-beat stream plus tail and return to IDLE.
  task automatic check_out_a(input int exp_iter);
    int t = 0;
    while (!ia.x_rd_en && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("a_out_reached", ia.x_rd_en, 1);
    if (!ia.x_rd_en) return;
    check("a_iter_at_out", ia.iter_count, 32'(exp_iter));
    for (int k = 0; k < 18; k++) begin
      check("a_rd_en", ia.x_rd_en, 32'(k < 16));
      if (k < 16) check("a_rd_addr", ia.x_rd_addr, 32'(k));
      check("a_out_valid", ia.out_valid, 32'(k >= 1 && k <= 16));
      check("a_busy_out", ia.busy, 32'(k < 17));
      if (k < 17) @(negedge clk);
    end
    check("a_iter_held", ia.iter_count, 32'(exp_iter));
  endtask

  typedef struct {
    logic       in_en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       x_clr;
    logic       upd_start;
    logic       busy;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int t;
    int xclr_cyc;

    // Gapped load: samples 0..5, three idle cycles, samples 6..15, then in_en during ISSUE.
    for (int v = 0; v < 20; v++) begin
      vecs[v].in_en     = !(v >= 6 && v <= 8);
      vecs[v].wr_en     = !(v >= 6 && v <= 8) && (v < 19);
      vecs[v].wr_addr   = (v <= 5) ? 4'(v) : (v <= 8) ? 4'd6 : (v < 19) ? 4'(v - 3) : 4'd0;
      vecs[v].x_clr     = (v == 18);
      vecs[v].upd_start = (v == 19);
      vecs[v].busy      = (v != 0);
    end

    reset    = 1'b1;
    ia.in_en = 1'b0;
    ib.in_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", ia.busy, 0);
    check("rst_upd_start", ia.upd_start, 0);
    check("rst_upd_idx", ia.upd_idx, 0);
    check("rst_x_rd_en", ia.x_rd_en, 0);
    check("rst_x_rd_addr", ia.x_rd_addr, 0);
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_iter", ia.iter_count, 0);
    check("rst_wr_addr", ia.b_wr_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    lat_a = 1;
    small_mode = 1;
    for (int v = 0; v < 20; v++) begin
      ia.in_en = vecs[v].in_en;
      #2;
      check("vec_wr_en", ia.b_wr_en, vecs[v].wr_en);
      check("vec_wr_addr", ia.b_wr_addr, vecs[v].wr_addr);
      check("vec_x_clr", ia.x_clr, vecs[v].x_clr);
      check("vec_upd_start", ia.upd_start, vecs[v].upd_start);
      check("vec_busy", ia.busy, vecs[v].busy);
      @(negedge clk);
    end
    ia.in_en = 1'b0;
    check_out_a(8);
    check("a_starts_conv8", starts_a, 128);

    // Abort in WAIT of row 7, sweep 3, then reload from scratch.
    starts_a   = 0;
    dones_a    = 0;
    lat_a      = 3;
    small_mode = 0;
    @(negedge clk);
    load_a();
    t = 0;
    while (starts_a < 40 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("pre_rst_idx", ia.upd_idx, 7);
    check("pre_rst_iter", ia.iter_count, 2);
    check("pre_rst_busy", ia.busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", ia.busy, 0);
    check("mid_rst_upd_start", ia.upd_start, 0);
    check("mid_rst_upd_idx", ia.upd_idx, 0);
    check("mid_rst_iter", ia.iter_count, 0);
    check("mid_rst_x_rd_en", ia.x_rd_en, 0);
    check("mid_rst_out_valid", ia.out_valid, 0);
    check("mid_rst_wr_addr", ia.b_wr_addr, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    starts_a   = 0;
    dones_a    = 0;
    small_mode = 2;
    inj_issue  = 1'b1;
    inj_out    = 1'b1;
    @(negedge clk);
    load_a();
    check_out_a(9);
    check("a_starts_conv9", starts_a, 144);
    inj_issue = 1'b0;
    inj_out   = 1'b0;

    // Sweep cap of 4 with latency 3 on dut_b.
    @(negedge clk);
    xclr_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      ib.in_en = 1'b1;
      #1;
      check("b_wr_addr", ib.b_wr_addr, 32'(i));
      if (ib.x_clr) xclr_cyc = cyc;
      @(negedge clk);
    end
    ib.in_en = 1'b0;
    check("b_x_clr_seen", 32'(xclr_cyc != 0), 1);
    t = 0;
    while (!ib.x_rd_en && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("b_out_reached", ib.x_rd_en, 1);
    check("b_first_rd_delay", 32'(cyc - xclr_cyc), 32'(4 * (16 * 4 + 1) + 1));
    check("b_iter_cap", ib.iter_count, 4);
    check("b_starts", starts_b, 64);
    for (int k = 0; k < 17; k++) begin
      check("b_rd_en", ib.x_rd_en, 32'(k < 16));
      if (k < 16) check("b_rd_addr", ib.x_rd_addr, 32'(k));
      check("b_out_valid", ib.out_valid, 32'(k >= 1));
      if (k == 1) check("b_first_valid_delay", 32'(cyc - xclr_cyc), 32'(4 * (16 * 4 + 1) + 2));
      @(negedge clk);
    end
    check("b_valid_drop", ib.out_valid, 0);
    check("b_idle", ib.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
